// File: rtl/seq_checker.sv
// seq_checker
//   Receive-side checker for an incrementing-counter stream (modulo
//   2^WIDTH). It acquires lock on a +1-per-sample sequence, then flags and
//   counts every break in the sequence while locked.
//
// Ports
//   clk_i           rising-edge clock
//   rst_n_i         asynchronous active-low reset
//   sync_clr_i      synchronous re-arm to IDLE; counters and last_err_val kept
//   din_i           observed sample
//   din_vld_i       din_i valid this cycle
//   locked_o        1 while in LOCKED
//   err_pulse_o     one-cycle pulse per break detected in LOCKED
//   err_cnt_o       breaks seen in LOCKED, saturating
//   samp_cnt_o      accepted samples, wrapping
//   exp_val_o       next expected value
//   last_err_val_o  din_i value of the most recent break
//
// State    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no reference yet; the next accepted sample seeds exp_val
// ACQUIRE  | counting consecutive correct increments toward LOCK_COUNT
// LOCKED   | sequence tracked; a mismatch is a counted break
module seq_checker #(
  parameter int WIDTH      = 4,
  parameter int CNT_W      = 16,
  parameter int LOCK_COUNT = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             sync_clr_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             din_vld_i,
  output logic             locked_o,
  output logic             err_pulse_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] samp_cnt_o,
  output logic [WIDTH-1:0] exp_val_o,
  output logic [WIDTH-1:0] last_err_val_o
);

  // Run counter wide enough to hold LOCK_COUNT itself.
  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] samp_cnt_q, samp_cnt_d;
  logic [WIDTH-1:0] last_err_q, last_err_d;
  logic             err_pulse_q, err_pulse_d;
  logic [RUN_W-1:0] run_inc;

  assign run_inc = run_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      run_q       <= '0;
      exp_q       <= '0;
      err_cnt_q   <= '0;
      samp_cnt_q  <= '0;
      last_err_q  <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      exp_q       <= exp_d;
      err_cnt_q   <= err_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      last_err_q  <= last_err_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    exp_d       = exp_q;
    err_cnt_d   = err_cnt_q;
    samp_cnt_d  = samp_cnt_q;
    last_err_d  = last_err_q;
    err_pulse_d = 1'b0;

    // A re-arm drops any concurrent sample entirely.
    if (sync_clr_i) begin
      state_d = IDLE;
      run_d   = '0;
      exp_d   = '0;
    end else if (din_vld_i) begin
      samp_cnt_d = samp_cnt_q + 1'b1;
      // Every accepted sample re-seeds the expectation, match or not.
      exp_d      = din_i + 1'b1;
      case (state_q)
        IDLE: begin
          run_d   = '0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (din_i == exp_q) begin
            run_d = run_inc;
            if (run_inc == LOCK_RUN) state_d = LOCKED;
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (din_i != exp_q) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            last_err_d  = din_i;
            run_d       = '0;
            state_d     = ACQUIRE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign locked_o       = (state_q == LOCKED);
  assign err_pulse_o    = err_pulse_q;
  assign err_cnt_o      = err_cnt_q;
  assign samp_cnt_o     = samp_cnt_q;
  assign exp_val_o      = exp_q;
  assign last_err_val_o = last_err_q;

endmodule

// File: tb/tb_seq_checker.sv
module tb_seq_checker;
  localparam int W  = 4;
  localparam int LC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, sync_clr, din_vld;
  logic [W-1:0] din;

  logic         locked, err_pulse;
  logic [15:0]  err_cnt, samp_cnt;
  logic [W-1:0] exp_val, last_err;

  logic         locked_s, err_pulse_s;
  logic [1:0]   err_cnt_s, samp_cnt_s;
  logic [W-1:0] exp_val_s, last_err_s;

  seq_checker #(.WIDTH(W), .CNT_W(16), .LOCK_COUNT(LC)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .sync_clr_i(sync_clr), .din_i(din),
    .din_vld_i(din_vld), .locked_o(locked), .err_pulse_o(err_pulse),
    .err_cnt_o(err_cnt), .samp_cnt_o(samp_cnt), .exp_val_o(exp_val),
    .last_err_val_o(last_err));

  seq_checker #(.WIDTH(W), .CNT_W(2), .LOCK_COUNT(LC)) dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .sync_clr_i(sync_clr), .din_i(din),
    .din_vld_i(din_vld), .locked_o(locked_s), .err_pulse_o(err_pulse_s),
    .err_cnt_o(err_cnt_s), .samp_cnt_o(samp_cnt_s), .exp_val_o(exp_val_s),
    .last_err_val_o(last_err_s));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: integer bookkeeping straight from the sequence rules.
  int m_samp, m_err, m_run, m_exp, m_last;
  bit m_have, m_locked, m_pulse;

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic m_reset();
    m_samp = 0; m_err = 0; m_run = 0; m_exp = 0; m_last = 0;
    m_have = 0; m_locked = 0; m_pulse = 0;
  endtask

  // Drive one cycle of stimulus, let the edge happen, advance the model.
  task automatic step(input bit vld, input bit clr, input int d);
    din_vld = vld; sync_clr = clr; din = W'(d);
    @(posedge clk); #1;
    m_pulse = 0;
    if (clr) begin
      m_have = 0; m_locked = 0; m_run = 0; m_exp = 0;
    end else if (vld) begin
      m_samp++;
      if (!m_have) begin
        m_have = 1; m_run = 0;
      end else if ((d % 16) == m_exp) begin
        if (!m_locked) begin
          m_run++;
          if (m_run >= LC) m_locked = 1;
        end
      end else begin
        if (m_locked) begin
          m_err++; m_last = d % 16; m_pulse = 1;
        end
        m_locked = 0; m_run = 0;
      end
      m_exp = (d + 1) % 16;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #3;
    m_reset();
    rst_n = 1'b1; #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sync_clr = 1'b0;
    m_reset();
    for (int i = 0; i < 5; i++) begin
      din = W'($urandom); din_vld = 1'($urandom);
      @(posedge clk); #1;
      n_chk++;
      if ({locked, err_pulse, err_cnt, samp_cnt, exp_val, last_err} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got l=%0b p=%0b e=%0d s=%0d x=%0h le=%0h, want all 0",
                 locked, err_pulse, err_cnt, samp_cnt, exp_val, last_err);
      end
      n_chk++;
      if ({locked_s, err_pulse_s, err_cnt_s, samp_cnt_s, exp_val_s, last_err_s} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs_small: got nonzero outputs, want all 0");
      end
    end
    rst_n = 1'b1; #1;
  endtask

  task automatic test_lock();
    for (int v = 0; v < 4; v++) begin
      step(1, 0, v);
      n_chk++;
      if (locked !== (v >= 2)) begin
        n_fail++;
        $display("FAIL lock_locked din=%0d: got %0b want %0b", v, locked, (v >= 2));
      end
    end
    n_chk++;
    if (exp_val !== 4'h4) begin n_fail++; $display("FAIL lock_exp: got %0h want 4", exp_val); end
    n_chk++;
    if (samp_cnt !== 16'd4) begin n_fail++; $display("FAIL lock_samp: got %0d want 4", samp_cnt); end
    n_chk++;
    if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL lock_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_wrap();
    for (int v = 4; v < 14; v++) step(1, 0, v);
    for (int v = 14; v < 18; v++) begin
      step(1, 0, v % 16);
      n_chk++;
      if (err_pulse !== 1'b0 || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap din=%0h: got pulse=%0b locked=%0b want 0/1", v % 16, err_pulse, locked);
      end
    end
    n_chk++;
    if (exp_val !== 4'h2) begin n_fail++; $display("FAIL wrap_exp: got %0h want 2", exp_val); end
  endtask

  task automatic test_break();
    for (int v = 2; v < 7; v++) step(1, 0, v);
    step(1, 0, 9);
    n_chk++;
    if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL break_pulse: got %0b want 1", err_pulse); end
    n_chk++;
    if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL break_cnt: got %0d want 1", err_cnt); end
    n_chk++;
    if (last_err !== 4'h9) begin n_fail++; $display("FAIL break_last: got %0h want 9", last_err); end
    n_chk++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL break_unlock: got %0b want 0", locked); end
    step(1, 0, 10);
    n_chk++;
    if (err_pulse !== 1'b0 || locked !== 1'b0) begin
      n_fail++; $display("FAIL break_after_A: got pulse=%0b locked=%0b want 0/0", err_pulse, locked);
    end
    step(1, 0, 11);
    n_chk++;
    if (locked !== 1'b1 || exp_val !== 4'hC) begin
      n_fail++; $display("FAIL break_relock: got locked=%0b exp=%0h want 1/C", locked, exp_val);
    end
  endtask

  task automatic test_clear_gaps();
    int s0, e0;
    s0 = m_samp; e0 = m_err;
    step(1, 1, 3);
    n_chk++;
    if (locked !== 1'b0 || exp_val !== 4'h0) begin
      n_fail++; $display("FAIL clear_idle: got locked=%0b exp=%0h want 0/0", locked, exp_val);
    end
    n_chk++;
    if (samp_cnt !== 16'(s0) || err_cnt !== 16'(e0)) begin
      n_fail++; $display("FAIL clear_counters: got s=%0d e=%0d want %0d/%0d", samp_cnt, err_cnt, s0, e0);
    end
    step(1, 0, 0);
    step(0, 0, int'($urandom_range(0, 15)));
    step(1, 0, 1);
    step(0, 0, int'($urandom_range(0, 15)));
    step(0, 0, int'($urandom_range(0, 15)));
    step(1, 0, 2);
    n_chk++;
    if (locked !== 1'b1 || err_pulse !== 1'b0) begin
      n_fail++; $display("FAIL gaps_lock: got locked=%0b pulse=%0b want 1/0", locked, err_pulse);
    end
    step(0, 0, 9);
    step(1, 0, 3);
    n_chk++;
    if (locked !== 1'b1 || err_pulse !== 1'b0 || err_cnt !== 16'(e0) || samp_cnt !== 16'(s0 + 4)) begin
      n_fail++;
      $display("FAIL gaps_hold: got l=%0b p=%0b e=%0d s=%0d want 1/0/%0d/%0d",
               locked, err_pulse, err_cnt, samp_cnt, e0, s0 + 4);
    end
  endtask

  task automatic test_saturation();
    int b;
    for (int k = 0; k < 5; k++) begin
      b = (m_exp + 5) % 16;
      step(1, 0, b);
      n_chk++;
      if (err_pulse_s !== 1'b1 || err_cnt_s !== 2'(sat(m_err, 3))) begin
        n_fail++;
        $display("FAIL sat_break%0d: got pulse=%0b cnt=%0d want 1/%0d", k, err_pulse_s, err_cnt_s, sat(m_err, 3));
      end
      step(1, 0, (b + 1) % 16);
      step(1, 0, (b + 2) % 16);
    end
    n_chk++;
    if (err_cnt_s !== 2'd3) begin n_fail++; $display("FAIL sat_final: got %0d want 3", err_cnt_s); end
    n_chk++;
    if (err_cnt !== 16'(m_err)) begin n_fail++; $display("FAIL sat_wide: got %0d want %0d", err_cnt, m_err); end
    n_chk++;
    if (samp_cnt_s !== 2'(m_samp % 4)) begin
      n_fail++; $display("FAIL sat_samp_wrap: got %0d want %0d", samp_cnt_s, m_samp % 4);
    end
  endtask

  task automatic test_random();
    bit vld, clr;
    int d;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        do_reset();
        n_chk++;
        if (locked !== 1'b0 || samp_cnt !== 16'd0 || err_cnt !== 16'd0) begin
          n_fail++; $display("FAIL rand_midreset: got l=%0b s=%0d e=%0d want 0/0/0", locked, samp_cnt, err_cnt);
        end
      end
      vld = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 39) == 0);
      d   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : m_exp;
      step(vld, clr, d);
      n_chk++;
      if (locked !== m_locked || err_pulse !== m_pulse) begin
        n_fail++; $display("FAIL rand_flags i=%0d: got l=%0b p=%0b want %0b/%0b", i, locked, err_pulse, m_locked, m_pulse);
      end
      n_chk++;
      if (err_cnt !== 16'(sat(m_err, 65535)) || samp_cnt !== 16'(m_samp % 65536)) begin
        n_fail++; $display("FAIL rand_counts i=%0d: got e=%0d s=%0d want %0d/%0d", i, err_cnt, samp_cnt, m_err, m_samp);
      end
      n_chk++;
      if (exp_val !== 4'(m_exp) || last_err !== 4'(m_last)) begin
        n_fail++; $display("FAIL rand_vals i=%0d: got x=%0h le=%0h want %0h/%0h", i, exp_val, last_err, m_exp, m_last);
      end
      n_chk++;
      if (err_cnt_s !== 2'(sat(m_err, 3)) || samp_cnt_s !== 2'(m_samp % 4)) begin
        n_fail++; $display("FAIL rand_small i=%0d: got e=%0d s=%0d want %0d/%0d", i, err_cnt_s, samp_cnt_s, sat(m_err, 3), m_samp % 4);
      end
    end
  endtask

  // Upstream register stage modelled in the bench: q clears during the
  // test's active-high reset and counts afterwards; valid = ~rst_tb.
  task automatic test_system();
    bit rst_tb;
    int q, nsamp;
    do_reset();
    rst_tb = 1; q = 0; nsamp = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) rst_tb = 0;
      step(!rst_tb, 0, q);
      if (!rst_tb) begin
        nsamp++;
        if (nsamp == LC + 1) begin
          n_chk++;
          if (locked !== 1'b1) begin n_fail++; $display("FAIL sys_lock: got %0b want 1", locked); end
        end
        q = (q + 1) % 16;
      end
    end
    n_chk++;
    if (err_cnt !== 16'd0 || locked !== 1'b1) begin
      n_fail++; $display("FAIL sys_final: got e=%0d l=%0b want 0/1", err_cnt, locked);
    end
  endtask

  initial begin
    rst_n = 1'b0; sync_clr = 1'b0; din_vld = 1'b0; din = '0;
    #2;
    test_reset();
    test_lock();
    test_wrap();
    test_break();
    test_clear_gaps();
    test_saturation();
    test_random();
    test_system();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
